tile_scroll_sched: RTL
======================

TILE_SCROLL_SCHED -- requirements
Module: tile_scroll_sched

Interface
REQ-001 SHALL have parameter TICK_DIV, default 833333, the number of clock cycles per frame tick (50 MHz / 60 Hz).
REQ-002 SHALL have parameter ROW_H, default 40, the row height in pixels and the offset wrap value.
REQ-003 SHALL have parameter SEED, default 8'hA5, the LFSR reset value; SEED=0 SHALL be replaced by 8'h01.
REQ-004 SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port startn, input, 1 bit: active-low start; it is sampled only in IDLE.
REQ-007 SHALL have port pause, input, 1 bit: while high, frame ticks are ignored.
REQ-008 SHALL have port isDrawingDone, input, 1 bit: completion flag from the drawing controller.
REQ-009 SHALL have port draw_go, output, 1 bit: request to the drawing controller to erase and redraw all rows.
REQ-010 SHALL have port offset, output, 6 bits: vertical scroll offset within a row, range 0..ROW_H-1.
REQ-011 SHALL have port lane_code, output, 18 bits: six 3-bit row codes; [2:0] is row 0 (top).
- Code 0 = no tile.
- Codes 1..4 = lanes at x=120/140/160/180.
REQ-012 SHALL have port sched_st, output, 2 bits: current FSM state.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag meaning a tick arrived while a draw was in progress.

Function
REQ-014 SHALL implement the FSM states IDLE=0, WAIT_TICK=1, DRAW=2, HOLD=3.
REQ-015 SHALL run a tick counter 0..TICK_DIV-1 in every state except IDLE.
- A tick is the cycle in which count==TICK_DIV-1; the counter then wraps to 0.
- In IDLE the counter is held at 0.
REQ-016 In IDLE, SHALL move to WAIT_TICK on the cycle after startn is sampled low; otherwise it SHALL stay in IDLE.
REQ-017 In WAIT_TICK, a tick with pause=0 SHALL move the FSM to DRAW and register draw_go=1 on the same edge.
REQ-018 In WAIT_TICK, a tick with pause=1 SHALL be discarded and the FSM SHALL stay in WAIT_TICK.
REQ-019 In DRAW, draw_go SHALL stay 1 until isDrawingDone is sampled 1; the FSM then moves to HOLD with draw_go=0 from that edge.
REQ-020 In HOLD, the FSM SHALL stay until isDrawingDone is sampled 0 (the four-phase handshake completes), then:
- perform the scroll update (REQ-021);
- move to WAIT_TICK.
REQ-021 The scroll update SHALL be:
- If offset<ROW_H-1: offset increments by 1.
- If offset==ROW_H-1: offset becomes 0, and the rows shift:
  - row[i] takes row[i-1] for i=5..1;
  - row0 takes {1'b0, lfsr[1:0]} + 1;
  - the LFSR advances one step.
REQ-022 The LFSR SHALL be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1 (feedback = l[7]^l[5]^l[4]^l[3], shifted into bit 0), and SHALL never reach 0.
REQ-023 offset, lane_code and the LFSR SHALL change only during the scroll update; they SHALL be stable whenever draw_go=1.
REQ-024 A tick occurring in DRAW or HOLD SHALL set overrun=1 and be dropped (no queued draw).
- overrun is cleared only by reset or by the IDLE->WAIT_TICK transition.
REQ-025 When a tick and the isDrawingDone edge fall on the same cycle, the handshake transition SHALL proceed and overrun SHALL still be set.
REQ-026 All outputs SHALL be driven directly from registers (no combinational paths from inputs to outputs).

Reset
REQ-027 When resetn=0, the block SHALL immediately, regardless of clock, set:
- sched_st=IDLE;
- draw_go=0;
- offset=0;
- lane_code=0;
- overrun=0;
- tick counter=0;
- LFSR=SEED (or 8'h01 if SEED=0).
REQ-028 A reset asserted mid-DRAW SHALL drop draw_go within the same cycle; no scroll update SHALL occur.
REQ-029 After resetn deasserts, the block SHALL remain in IDLE until startn is sampled low.

Verification (TICK_DIV=4, ROW_H=4, SEED=8'hA5)
REQ-030 Start and first draw: pulse startn low for 1 cycle -> sched_st=1; draw_go rises 4 cycles after entering WAIT_TICK; offset=0 while draw_go=1.
REQ-031 Handshake: after REQ-030, hold isDrawingDone=0 for 10 cycles -> draw_go stays 1. Then drive isDrawingDone=1 -> draw_go=0. Then drive isDrawingDone=0 -> offset=1 and sched_st=1.
REQ-032 Row wrap: complete 4 handshakes -> offset returns to 0 and lane_code[2:0]=(8'hA5 & 3)+1=2; after 4 more handshakes the old row0 (2) sits in lane_code[5:3].
REQ-033 Overrun: hold isDrawingDone=0 for more than 4 cycles in DRAW -> overrun=1 and only one draw_go pulse is issued; startn in IDLE after reset clears overrun.
REQ-034 Pause: pause=1 throughout WAIT_TICK for 20 cycles -> draw_go stays 0 and offset stays unchanged; release pause -> draw_go=1 at the next tick.
REQ-035 Async reset: assert resetn=0 mid-DRAW between clock edges -> draw_go=0, offset=0, lane_code=0 and sched_st=0 immediately; LFSR reload is confirmed by REQ-032 repeating identically.

Source files
------------

// File: rtl/tile_scroll_sched.sv
// Tile scroll scheduler: paces redraws of six tile rows to a frame tick,
// handshakes with the drawing controller and scrolls the rows downward.
module tile_scroll_sched #(
    parameter int unsigned TICK_DIV = 833333,
    parameter int unsigned ROW_H    = 40,
    parameter logic [7:0]  SEED     = 8'hA5
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        startn,
    input  logic        pause,
    input  logic        isDrawingDone,
    output logic        draw_go,
    output logic [5:0]  offset,
    output logic [17:0] lane_code,
    output logic [1:0]  sched_st,
    output logic        overrun
);

    localparam int unsigned CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [7:0]  SeedEff = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitTick = 2'd1,
        StDraw     = 2'd2,
        StHold     = 2'd3
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [7:0]        lfsr_q;
    logic              tick;
    logic              lfsr_fb;

    // Pause masks the tick everywhere; the divider itself keeps counting.
    assign tick     = (state_q != StIdle) && (cnt_q == CntW'(TICK_DIV - 1)) && !pause;
    assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign sched_st = state_q;

    // Frame divider, handshake FSM and scroll state, all registered.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            lfsr_q    <= SeedEff;
            draw_go   <= 1'b0;
            offset    <= '0;
            lane_code <= '0;
            overrun   <= 1'b0;
        end else begin
            if (state_q == StIdle || cnt_q == CntW'(TICK_DIV - 1)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end

            case (state_q)
                StIdle: begin
                    if (!startn) begin
                        state_q <= StWaitTick;
                        overrun <= 1'b0;
                    end
                end
                StWaitTick: begin
                    if (tick) begin
                        state_q <= StDraw;
                        draw_go <= 1'b1;
                    end
                end
                StDraw: begin
                    if (tick) overrun <= 1'b1;
                    if (isDrawingDone) begin
                        state_q <= StHold;
                        draw_go <= 1'b0;
                    end
                end
                StHold: begin
                    if (tick) overrun <= 1'b1;
                    // Scroll only once the controller has dropped its done flag.
                    if (!isDrawingDone) begin
                        state_q <= StWaitTick;
                        if (offset == 6'(ROW_H - 1)) begin
                            offset    <= '0;
                            lane_code <= {lane_code[14:0], {1'b0, lfsr_q[1:0]} + 3'd1};
                            lfsr_q    <= {lfsr_q[6:0], lfsr_fb};
                        end else begin
                            offset <= offset + 6'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
